// File: rtl/dbg_env_pkg.sv
// -----------------------------------------------------------------------------
// dbg_env_pkg
//   Shared definitions for the FPGA debug wrapper's data-port blocks.
//   - state_t : CPU reset sequencer states (CLEAR, HOLD, RUN)
//   - *_OFS   : MMIO word offsets relative to the MMIO base address
// -----------------------------------------------------------------------------
package dbg_env_pkg;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,  // sweeping zeros into the RAM, CPU held in reset
      HOLD  = 2'd1,  // waiting for the run switch to be stably low
      RUN   = 2'd2   // CPU released, bus accesses honoured
   } state_t;

   localparam int unsigned LED_OFS = 0;
   localparam int unsigned SW_OFS  = 1;
   localparam int unsigned CNT_OFS = 2;

endpackage : dbg_env_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for slow asynchronous inputs (board switches).
//   Each bit is synchronised independently; no multi-bit coherency is implied.
// Ports:
//   clk   in  1      destination clock
//   rst   in  1      asynchronous active-high reset, clears both stages
//   d     in  WIDTH  asynchronous input
//   q     out WIDTH  synchronised output (2 cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its source; with blocking '=' the second stage would
   // see the first stage's new value and the chain would collapse to one flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
//   Data RAM plus memory-mapped I/O on the CPU data port, with a CPU reset
//   sequencer. Word addressing throughout.
//     0 .. DEPTH-1      : RAM (read/write)
//     MMIO_BASE + 0     : LED register (write takes low NUM_LED bits)
//     MMIO_BASE + 1     : synchronised switches (read-only)
//     MMIO_BASE + 2     : free-running cycle counter (read-only)
//     anything else     : reads 0, writes dropped, sets ERR while in RUN
//   The sequencer zeroes the RAM (CLEAR), waits for SW[0] to be stably low for
//   DEBOUNCE cycles (HOLD), then releases the CPU (RUN). SW[0] high in RUN
//   aborts back to CLEAR.
// Ports:
//   CLK100MHZ               in  1       sole clock
//   RST                     in  1       asynchronous active-high reset
//   MEM_ACCESS_ADDRESS_BUS  in  ADDR_W  CPU word address
//   MEM_ACCESS_READ_WRN     in  1       1 = read, 0 = write
//   MEM_ACCESS_DATA_OUT_BUS in  DATA_W  CPU write data
//   MEM_ACCESS_DATA_IN_BUS  out DATA_W  combinational read data to CPU
//   SW                      in  NUM_SW  raw board switches, SW[0] = run/hold
//   LED                     out NUM_LED LED register
//   CPU_RST_N               out 1       registered active-low CPU reset
//   ERR                     out 1       sticky out-of-map access flag
// -----------------------------------------------------------------------------
module dmem_mmio
   import dbg_env_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned MMIO_BASE = 32'h100,
   parameter int unsigned NUM_LED   = 4,
   parameter int unsigned NUM_SW    = 4,
   parameter int unsigned DEBOUNCE  = 1000
) (
   input  logic              CLK100MHZ,
   input  logic              RST,
   input  logic [ADDR_W-1:0] MEM_ACCESS_ADDRESS_BUS,
   input  logic              MEM_ACCESS_READ_WRN,
   input  logic [DATA_W-1:0] MEM_ACCESS_DATA_OUT_BUS,
   output logic [DATA_W-1:0] MEM_ACCESS_DATA_IN_BUS,
   input  logic [NUM_SW-1:0] SW,
   output logic [NUM_LED-1:0] LED,
   output logic              CPU_RST_N,
   output logic              ERR
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);

   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DEPTH - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE - 1);
   localparam logic [ADDR_W-1:0] RAM_TOP  = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LED_ADDR = ADDR_W'(MMIO_BASE + LED_OFS);
   localparam logic [ADDR_W-1:0] SW_ADDR  = ADDR_W'(MMIO_BASE + SW_OFS);
   localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(MMIO_BASE + CNT_OFS);

   state_t              state, state_next;
   logic [IDX_W-1:0]    idx;
   logic [DEB_W-1:0]    deb_cnt;
   logic [NUM_LED-1:0]  led;
   logic [DATA_W-1:0]   counter;
   logic                err;
   logic                cpu_rst_n;

   logic [NUM_SW-1:0]   sw_s;
   logic                sw0_s;

   logic [DATA_W-1:0]   ram [DEPTH];
   logic                ram_we;
   logic [IDX_W-1:0]    ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;

   logic                in_ram, is_led, is_sw, is_cnt, unmapped;
   logic                cpu_wr;
   logic [DATA_W-1:0]   rdata;

   // ---------------------------------------------------------------- switches
   sync_2ff #(.WIDTH(NUM_SW)) u_sw_sync (
      .clk (CLK100MHZ),
      .rst (RST),
      .d   (SW),
      .q   (sw_s)
   );

   assign sw0_s = sw_s[0];

   // ---------------------------------------------------------------- decode
   assign in_ram   = (MEM_ACCESS_ADDRESS_BUS < RAM_TOP);
   assign is_led   = (MEM_ACCESS_ADDRESS_BUS == LED_ADDR);
   assign is_sw    = (MEM_ACCESS_ADDRESS_BUS == SW_ADDR);
   assign is_cnt   = (MEM_ACCESS_ADDRESS_BUS == CNT_ADDR);
   assign unmapped = !(in_ram || is_led || is_sw || is_cnt);

   // A CPU write only lands in RUN and only if the run switch is not
   // simultaneously requesting an abort.
   assign cpu_wr = (state == RUN) && !MEM_ACCESS_READ_WRN && !sw0_s;

   // ------------------------------------------------- next state / RAM port
   // The single RAM write port is shared between the CLEAR sweep and the CPU.
   // NOTE: every signal driven here gets a default before the case statement;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      ram_we     = 1'b0;
      ram_waddr  = '0;
      ram_wdata  = '0;
      case (state)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = idx;
            if (idx == IDX_LAST) state_next = HOLD;
         end
         HOLD: begin
            if (!sw0_s && deb_cnt == DEB_LAST) state_next = RUN;
         end
         RUN: begin
            if (sw0_s) begin
               state_next = CLEAR;
            end else if (cpu_wr && in_ram) begin
               ram_we    = 1'b1;
               ram_waddr = MEM_ACCESS_ADDRESS_BUS[IDX_W-1:0];
               ram_wdata = MEM_ACCESS_DATA_OUT_BUS;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   // ---------------------------------------------------------------- state
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) state <= CLEAR;
      else     state <= state_next;
   end

   // ------------------------------------------------------- control registers
   always_ff @(posedge CLK100MHZ or posedge RST) begin
      if (RST) begin
         idx       <= '0;
         deb_cnt   <= '0;
         led       <= '0;
         counter   <= '0;
         err       <= 1'b0;
         cpu_rst_n <= 1'b0;
      end else begin
         // Registered off next state so the CPU sees reset release on the
         // same edge the sequencer enters RUN.
         cpu_rst_n <= (state_next == RUN);

         // idx parks at 0 outside CLEAR, so any entry into CLEAR restarts
         // the sweep from the bottom.
         if (state == CLEAR && idx != IDX_LAST) idx <= idx + IDX_W'(1);
         else                                   idx <= '0;

         // Any high sample of sw0_s in HOLD restarts the debounce window.
         if (state == HOLD && !sw0_s && deb_cnt != DEB_LAST)
            deb_cnt <= deb_cnt + DEB_W'(1);
         else
            deb_cnt <= '0;

         if (state == RUN) counter <= counter + DATA_W'(1);
         else              counter <= '0;

         if (state == CLEAR)         led <= '0;
         else if (cpu_wr && is_led)  led <= MEM_ACCESS_DATA_OUT_BUS[NUM_LED-1:0];

         if (state == RUN) begin
            if (sw0_s)         err <= 1'b0;  // entering CLEAR
            else if (unmapped) err <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- RAM
   // NOTE: the array has no reset so it can map onto block RAM; its contents
   // are defined by the CLEAR sweep rather than by RST.
   always_ff @(posedge CLK100MHZ) begin
      if (ram_we) ram[ram_waddr] <= ram_wdata;
   end

   // ---------------------------------------------------------------- read mux
   always_comb begin
      rdata = '0;
      if (in_ram)      rdata                = ram[MEM_ACCESS_ADDRESS_BUS[IDX_W-1:0]];
      else if (is_led) rdata[NUM_LED-1:0]   = led;
      else if (is_sw)  rdata[NUM_SW-1:0]    = sw_s;
      else if (is_cnt) rdata                = counter;
   end

   assign MEM_ACCESS_DATA_IN_BUS = rdata;
   assign LED                    = led;
   assign CPU_RST_N              = cpu_rst_n;
   assign ERR                    = err;

endmodule : dmem_mmio

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
//   Self-checking bench for dmem_mmio (DEPTH=16, DEBOUNCE=8). Expected values
//   come from a word-array model of the RAM plus LED/ERR shadow values and
//   edge counts derived from the sequencer timing rules.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int DEPTH    = 16;
   localparam int NUM_LED  = 4;
   localparam int NUM_SW   = 4;
   localparam int DEBOUNCE = 8;
   localparam logic [31:0] BASE = 32'h100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] addr = '0;
   logic              rd_wrn = 1'b1;
   logic [DATA_W-1:0] wdata = '0;
   logic [DATA_W-1:0] rdata;
   logic [NUM_SW-1:0] sw = '0;
   logic [NUM_LED-1:0] led;
   logic              cpu_rst_n;
   logic              err;

   int n_cmp = 0;
   int n_bad = 0;

   logic [DATA_W-1:0]  mem_model [DEPTH];
   logic [NUM_LED-1:0] led_model;
   logic               err_model;

   always #5 clk = ~clk;

   dmem_mmio #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .MMIO_BASE(32'h100),
      .NUM_LED  (NUM_LED),
      .NUM_SW   (NUM_SW),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .CLK100MHZ              (clk),
      .RST                    (rst),
      .MEM_ACCESS_ADDRESS_BUS (addr),
      .MEM_ACCESS_READ_WRN    (rd_wrn),
      .MEM_ACCESS_DATA_OUT_BUS(wdata),
      .MEM_ACCESS_DATA_IN_BUS (rdata),
      .SW                     (sw),
      .LED                    (led),
      .CPU_RST_N              (cpu_rst_n),
      .ERR                    (err)
   );

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      addr   = '0;
      rd_wrn = 1'b1;
      wdata  = '0;
   endtask

   task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      addr   = a;
      rd_wrn = 1'b0;
      wdata  = d;
   endtask

   // Edges until CPU_RST_N reads high, or -1 if it never does.
   task automatic edges_to_run(output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (cpu_rst_n === 1'b1) begin
            n = i;
            return;
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
      led_model = '0;
      err_model = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      sw  = '0;
      bus_idle();
      repeat (3) step();
      n_cmp++;
      if (cpu_rst_n !== 1'b0) begin
         n_bad++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n);
      end
      n_cmp++;
      if (led !== '0) begin
         n_bad++; $display("FAIL reset_led: got %h want 0", led);
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++; $display("FAIL reset_err: got %b want 0", err);
      end
      addr = BASE + 2; #1;
      n_cmp++;
      if (rdata !== '0) begin
         n_bad++; $display("FAIL reset_counter: got %h want 0", rdata);
      end
      bus_idle();
      rst = 1'b0;
      edges_to_run(n);
      n_cmp++;
      if (n !== DEPTH + DEBOUNCE) begin
         n_bad++; $display("FAIL startup_edges: got %0d want %0d", n, DEPTH + DEBOUNCE);
      end
      model_clear();
      addr = BASE + 2; #1;
      n_cmp++;
      if (rdata !== '0) begin
         n_bad++; $display("FAIL first_run_counter: got %h want 0", rdata);
      end
      for (int i = 0; i < DEPTH; i++) begin
         addr = i; #1;
         n_cmp++;
         if (rdata !== mem_model[i]) begin
            n_bad++; $display("FAIL startup_ram[%0d]: got %h want %h", i, rdata, mem_model[i]);
         end
      end
      bus_idle();
   endtask

   task automatic test_ram();
      int a;
      logic [DATA_W-1:0] d;
      step();
      bus_write(5, 32'hDEADBEEF);
      step();
      mem_model[5] = 32'hDEADBEEF;
      bus_idle(); addr = 5; #1;
      n_cmp++;
      if (rdata !== 32'hDEADBEEF) begin
         n_bad++; $display("FAIL ram_deadbeef: got %h want deadbeef", rdata);
      end
      for (int k = 0; k < 40; k++) begin
         a = $urandom_range(0, DEPTH - 1);
         d = $urandom;
         bus_write(a, d);
         step();
         mem_model[a] = d;
         bus_idle();
         a = $urandom_range(0, DEPTH - 1);
         addr = a; #1;
         n_cmp++;
         if (rdata !== mem_model[a]) begin
            n_bad++; $display("FAIL ram_rand[%0d]: got %h want %h", a, rdata, mem_model[a]);
         end
      end
      // back-to-back writes, one per cycle
      for (int k = 0; k < 8; k++) begin
         a = $urandom_range(0, DEPTH - 1);
         d = $urandom;
         bus_write(a, d);
         step();
         mem_model[a] = d;
      end
      bus_idle();
      for (int i = 0; i < DEPTH; i++) begin
         addr = i; #1;
         n_cmp++;
         if (rdata !== mem_model[i]) begin
            n_bad++; $display("FAIL ram_b2b[%0d]: got %h want %h", i, rdata, mem_model[i]);
         end
      end
      bus_idle();
   endtask

   task automatic test_led();
      logic [DATA_W-1:0] d;
      step();
      bus_write(BASE, 32'hF5);
      step();
      led_model = 4'h5;
      bus_idle(); addr = BASE; #1;
      n_cmp++;
      if (led !== 4'h5) begin
         n_bad++; $display("FAIL led_f5: got %h want 5", led);
      end
      n_cmp++;
      if (rdata !== 32'h5) begin
         n_bad++; $display("FAIL led_read_f5: got %h want 5", rdata);
      end
      for (int k = 0; k < 4; k++) begin
         d = $urandom;
         bus_write(BASE, d);
         step();
         led_model = d[NUM_LED-1:0];
         bus_idle(); addr = BASE; #1;
         n_cmp++;
         if (rdata !== {{(DATA_W-NUM_LED){1'b0}}, led_model}) begin
            n_bad++; $display("FAIL led_rand: got %h want %h", rdata, led_model);
         end
      end
      bus_idle();
   endtask

   task automatic test_counter_ro();
      logic [DATA_W-1:0] c0, c1, swv;
      sw = {3'($urandom_range(1, 7)), 1'b0};
      repeat (3) step();
      swv = '0; swv[NUM_SW-1:0] = sw;
      addr = BASE + 1; #1;
      n_cmp++;
      if (rdata !== swv) begin
         n_bad++; $display("FAIL sw_read: got %h want %h", rdata, swv);
      end
      addr = BASE + 2; #1;
      c0 = rdata;
      repeat (10) step();
      c1 = rdata;
      n_cmp++;
      if (c1 - c0 !== 32'd10) begin
         n_bad++; $display("FAIL counter_delta: got %0d want 10", c1 - c0);
      end
      bus_write(BASE + 1, ~swv);
      step();
      bus_write(BASE + 2, 32'h0);
      step();
      bus_idle(); addr = BASE + 1; #1;
      n_cmp++;
      if (rdata !== swv) begin
         n_bad++; $display("FAIL sw_ro: got %h want %h", rdata, swv);
      end
      n_cmp++;
      if (err !== 1'b0) begin
         n_bad++; $display("FAIL ro_err: got %b want 0", err);
      end
      addr = BASE + 2; #1;
      n_cmp++;
      if (rdata === 32'h0 || rdata < c1) begin
         n_bad++; $display("FAIL counter_ro: got %h want >= %h", rdata, c1);
      end
      bus_idle();
   endtask

   task automatic test_oob();
      logic [DATA_W-1:0] d;
      step();
      d = $urandom | 32'h1;
      bus_write(32'h50, d);
      step();
      err_model = 1'b1;
      bus_idle();
      n_cmp++;
      if (err !== err_model) begin
         n_bad++; $display("FAIL oob_err: got %b want %b", err, err_model);
      end
      addr = 0; #1;
      n_cmp++;
      if (rdata !== mem_model[0]) begin
         n_bad++; $display("FAIL oob_alias: got %h want %h", rdata, mem_model[0]);
      end
      for (int k = 0; k < 4; k++) begin
         d = $urandom;
         bus_write(k + 1, d);
         step();
         mem_model[k + 1] = d;
      end
      bus_write(BASE + 3, 32'hFFFF_FFFF);
      step();
      bus_idle(); addr = BASE + 3; #1;
      n_cmp++;
      if (rdata !== '0) begin
         n_bad++; $display("FAIL oob_read: got %h want 0", rdata);
      end
      n_cmp++;
      if (err !== err_model) begin
         n_bad++; $display("FAIL err_sticky: got %b want %b", err, err_model);
      end
      for (int i = 0; i < DEPTH; i++) begin
         addr = i; #1;
         n_cmp++;
         if (rdata !== mem_model[i]) begin
            n_bad++; $display("FAIL oob_ram[%0d]: got %h want %h", i, rdata, mem_model[i]);
         end
      end
      bus_idle();
   endtask

   task automatic test_abort();
      logic [DATA_W-1:0] old;
      int n;
      step();
      old = $urandom | 32'h1;
      bus_write(3, old);
      step();
      mem_model[3] = old;
      bus_write(BASE, 32'hA);
      step();
      bus_idle();
      sw[0] = 1'b1;
      step();
      n_cmp++;
      if (cpu_rst_n !== 1'b1) begin
         n_bad++; $display("FAIL abort_edge1: got %b want 1", cpu_rst_n);
      end
      step();
      n_cmp++;
      if (cpu_rst_n !== 1'b1) begin
         n_bad++; $display("FAIL abort_edge2: got %b want 1", cpu_rst_n);
      end
      bus_write(3, ~old);
      step();
      n_cmp++;
      if (cpu_rst_n !== 1'b0) begin
         n_bad++; $display("FAIL abort_edge3: got %b want 0", cpu_rst_n);
      end
      bus_idle(); addr = 3; #1;
      n_cmp++;
      if (rdata !== old) begin
         n_bad++; $display("FAIL abort_write_dropped: got %h want %h", rdata, old);
      end
      bus_idle();
      sw[0] = 1'b0;
      edges_to_run(n);
      model_clear();
      n_cmp++;
      if (n !== DEPTH + DEBOUNCE) begin
         n_bad++; $display("FAIL abort_rerun_edges: got %0d want %0d", n, DEPTH + DEBOUNCE);
      end
      n_cmp++;
      if (led !== led_model) begin
         n_bad++; $display("FAIL abort_led: got %h want %h", led, led_model);
      end
      n_cmp++;
      if (err !== err_model) begin
         n_bad++; $display("FAIL abort_err: got %b want %b", err, err_model);
      end
      for (int i = 0; i < DEPTH; i++) begin
         addr = i; #1;
         n_cmp++;
         if (rdata !== mem_model[i]) begin
            n_bad++; $display("FAIL abort_ram[%0d]: got %h want %h", i, rdata, mem_model[i]);
         end
      end
      bus_idle();
   endtask

   // Mid-operation reset, then a one-cycle SW[0] glitch in HOLD that lands
   // where deb_cnt would have been 5 (HOLD edge DEPTH+6 after release).
   task automatic test_reset_glitch();
      int n;
      int want;
      step();
      bus_write(7, $urandom | 32'h1);
      step();
      bus_write(BASE, 32'hF);
      step();
      bus_write(32'h200, 32'h1);
      step();
      bus_idle();
      n_cmp++;
      if (err !== 1'b1 || led !== 4'hF) begin
         n_bad++; $display("FAIL pre_reset_state: got err=%b led=%h want err=1 led=f", err, led);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if (cpu_rst_n !== 1'b0 || led !== '0 || err !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: got rst_n=%b led=%h err=%b want 0/0/0", cpu_rst_n, led, err);
      end
      step();
      step();
      rst = 1'b0;
      model_clear();
      want = DEPTH + 6 + DEBOUNCE;
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (i == DEPTH + 3) sw[0] = 1'b1;
         if (i == DEPTH + 4) sw[0] = 1'b0;
         if (cpu_rst_n === 1'b1) begin
            n = i;
            break;
         end
      end
      n_cmp++;
      if (n !== want) begin
         n_bad++; $display("FAIL glitch_run_edges: got %0d want %0d", n, want);
      end
      for (int i = 0; i < DEPTH; i++) begin
         addr = i; #1;
         n_cmp++;
         if (rdata !== mem_model[i]) begin
            n_bad++; $display("FAIL reset_ram[%0d]: got %h want %h", i, rdata, mem_model[i]);
         end
      end
      bus_idle();
   endtask

   initial begin
      test_reset();
      test_ram();
      test_led();
      test_counter_ro();
      test_oob();
      test_abort();
      test_reset_glitch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_dmem_mmio
